// File: rtl/aibcr3_dcc_updn_gry7_if.sv
// Control and observation bundle for the DCC up/down Gray-code loop controller.
// The master side drives the comparator decisions and the override; the slave
// side (the controller) returns the Gray code, binary code and status flags.
interface aibcr3_dcc_updn_gry7_if;
  logic       en;
  logic       step_valid;
  logic       dcc_up;
  logic       gry_ovr_en;
  logic [6:0] gry_ovr;
  logic [6:0] grey;
  logic [6:0] code_bin;
  logic       lock;
  logic       sat_hi;
  logic       sat_lo;

  modport master (
    output en, step_valid, dcc_up, gry_ovr_en, gry_ovr,
    input  grey, code_bin, lock, sat_hi, sat_lo
  );

  modport slave (
    input  en, step_valid, dcc_up, gry_ovr_en, gry_ovr,
    output grey, code_bin, lock, sat_hi, sat_lo
  );
endinterface

// File: rtl/aibcr3_dcc_updn_gry7.sv
// Duty-cycle-correction loop controller.
// Comparator samples are majority-filtered by a signed accumulator. Each time
// the accumulator reaches +/-F, the 7-bit code takes one saturating step.
// The code is sent out as Gray, so the downstream thermometer decoder sees
// only one input bit change per step. Once the code has dithered back and forth
// LOCK_CNT times in a row, the code is frozen and lock is raised.
module aibcr3_dcc_updn_gry7 #(
  parameter int INIT_CODE = 64,
  parameter int FILT_W    = 4,
  parameter int LOCK_CNT  = 8
) (
  input logic                          CLKIN,
  input logic                          RST,
  aibcr3_dcc_updn_gry7_if.slave        dcc_if
);

  localparam int ACC_W = FILT_W + 1;
  localparam logic signed [ACC_W-1:0] F_POS   = ACC_W'(2 ** (FILT_W - 1));
  localparam logic signed [ACC_W-1:0] F_NEG   = -F_POS;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic [6:0]              INIT_BIN = 7'(INIT_CODE);
  localparam logic [3:0]              LOCK_THR = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Binary to reflected Gray: adjacent codes differ in exactly one bit.
  function automatic logic [6:0] bin2gray(input logic [6:0] b);
    return b ^ {1'b0, b[6:1]};
  endfunction

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [6:0]               code_q, code_d;
  logic [6:0]               grey_q, grey_d;
  logic [3:0]               rev_q, rev_d;
  logic                     last_dir_q, last_dir_d;   // 1 = last applied step was up
  logic                     last_vld_q, last_vld_d;   // last_dir holds a real step
  logic                     lock_q, lock_d;
  logic                     sat_hi_q, sat_hi_d;
  logic                     sat_lo_q, sat_lo_d;

  logic signed [ACC_W-1:0]  acc_n_s;
  logic                     req_up_s;
  logic                     req_dn_s;
  logic                     step_s;       // a code step was actually applied
  logic                     step_dir_s;   // direction of the applied step
  logic                     lock_hit_s;

  // Filter, saturating code step and reversal counting.
  always_comb begin
    acc_d      = acc_q;
    code_d     = code_q;
    sat_hi_d   = sat_hi_q;
    sat_lo_d   = sat_lo_q;
    rev_d      = rev_q;
    last_dir_d = last_dir_q;
    last_vld_d = last_vld_q;
    acc_n_s    = acc_q;
    req_up_s   = 1'b0;
    req_dn_s   = 1'b0;
    step_s     = 1'b0;
    step_dir_s = 1'b0;

    if (!dcc_if.en) begin
      // Dropping enable (entry to or stay in IDLE) discards filter and lock history.
      acc_d      = '0;
      rev_d      = 4'd0;
      last_vld_d = 1'b0;
    end else if (state_q == ST_TRACK && dcc_if.step_valid) begin
      acc_n_s  = dcc_if.dcc_up ? (acc_q + ACC_ONE) : (acc_q - ACC_ONE);
      req_up_s = (acc_n_s == F_POS);
      req_dn_s = (acc_n_s == F_NEG);
      if (req_up_s || req_dn_s) begin
        acc_d = '0;
      end else begin
        acc_d = acc_n_s;
      end
    end else begin
      acc_d = acc_q;
    end

    if (req_up_s) begin
      if (code_q != 7'd127) begin
        code_d     = code_q + 7'd1;
        sat_hi_d   = 1'b0;
        sat_lo_d   = 1'b0;
        step_s     = 1'b1;
        step_dir_s = 1'b1;
      end else begin
        sat_hi_d = 1'b1;
        sat_lo_d = 1'b0;
      end
    end else if (req_dn_s) begin
      if (code_q != 7'd0) begin
        code_d     = code_q - 7'd1;
        sat_hi_d   = 1'b0;
        sat_lo_d   = 1'b0;
        step_s     = 1'b1;
        step_dir_s = 1'b0;
      end else begin
        sat_hi_d = 1'b0;
        sat_lo_d = 1'b1;
      end
    end else begin
      code_d = code_q;
    end

    // Clipped requests never move the code, so they do not count as reversals.
    if (step_s) begin
      last_dir_d = step_dir_s;
      last_vld_d = 1'b1;
      if (!last_vld_q) begin
        rev_d = 4'd0;
      end else if (step_dir_s != last_dir_q) begin
        rev_d = rev_q + 4'd1;
      end else begin
        rev_d = 4'd0;
      end
    end else begin
      last_dir_d = last_dir_q;
    end

    lock_hit_s = step_s && (rev_d == LOCK_THR);
  end

  // Next-state logic of the loop FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dcc_if.en) state_d = ST_TRACK;
        else           state_d = ST_IDLE;
      end
      ST_TRACK: begin
        if (!dcc_if.en)      state_d = ST_IDLE;
        else if (lock_hit_s) state_d = ST_LOCKED;
        else                 state_d = ST_TRACK;
      end
      ST_LOCKED: begin
        if (!dcc_if.en) state_d = ST_IDLE;
        else            state_d = ST_LOCKED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: lock follows the next state, grey tracks the next code or the override.
  always_comb begin
    lock_d = (state_d == ST_LOCKED);
    if (dcc_if.gry_ovr_en) begin
      grey_d = dcc_if.gry_ovr;
    end else begin
      grey_d = bin2gray(code_d);
    end
  end

  // FSM state register.
  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; grey and code_bin load on the same edge.
  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      acc_q      <= '0;
      code_q     <= INIT_BIN;
      grey_q     <= bin2gray(INIT_BIN);
      rev_q      <= 4'd0;
      last_dir_q <= 1'b0;
      last_vld_q <= 1'b0;
      lock_q     <= 1'b0;
      sat_hi_q   <= 1'b0;
      sat_lo_q   <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      code_q     <= code_d;
      grey_q     <= grey_d;
      rev_q      <= rev_d;
      last_dir_q <= last_dir_d;
      last_vld_q <= last_vld_d;
      lock_q     <= lock_d;
      sat_hi_q   <= sat_hi_d;
      sat_lo_q   <= sat_lo_d;
    end
  end

  assign dcc_if.grey     = grey_q;
  assign dcc_if.code_bin = code_q;
  assign dcc_if.lock     = lock_q;
  assign dcc_if.sat_hi   = sat_hi_q;
  assign dcc_if.sat_lo   = sat_lo_q;

endmodule
